pc_sequencer: RTL

Program-counter and run-control stage sitting directly downstream of the jump-target lookup. Each cycle it takes the lookup's `absj`/`target` pair and loads the next instruction address, or increments. It also owns start/halt sequencing and keeps cycle and taken-jump counters for the test harness. Its `prog_ctr` output feeds the instruction ROM and loops back into the lookup's `prog_ctr` input.

---
 rtl/pc_seq_if.sv | 33 +++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pc_seq_if.sv
// Bundle of run-control, jump-lookup and status signals between the
// program-counter sequencer and its environment.
//   start/halt/stall  : run-control requests into the sequencer
//   absj/target       : taken-jump flag and destination from the jump lookup
//   prog_ctr          : current instruction address (to ROM and jump lookup)
//   busy/done         : run status
//   cycle_ct/jump_ct  : saturating cycle and taken-jump counters
// The master modport drives requests; the slave modport is the sequencer.
interface pc_seq_if #(
    parameter int D  = 12,
    parameter int CW = 16
);
    logic          start;
    logic          halt;
    logic          stall;
    logic          absj;
    logic [D-1:0]  target;
    logic [D-1:0]  prog_ctr;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_ct;
    logic [CW-1:0] jump_ct;

    modport master (
        output start, halt, stall, absj, target,
        input  prog_ctr, busy, done, cycle_ct, jump_ct
    );

    modport slave (
        input  start, halt, stall, absj, target,
        output prog_ctr, busy, done, cycle_ct, jump_ct
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter and run-control stage downstream of the jump-target lookup.
// Loads the jump target or increments the PC each running cycle, sequences
// IDLE -> RUN -> DONE, and keeps saturating cycle / taken-jump counters.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_seq_if slave (start, halt, stall, absj, target in;
//           prog_ctr, busy, done, cycle_ct, jump_ct out, all registered)
module pc_sequencer #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_r;
    state_e        state_nx_s;

    logic [D-1:0]  prog_ctr_r;
    logic [D-1:0]  prog_ctr_nx_s;
    logic [CW-1:0] cycle_ct_r;
    logic [CW-1:0] cycle_ct_nx_s;
    logic [CW-1:0] jump_ct_r;
    logic [CW-1:0] jump_ct_nx_s;
    logic          busy_r;
    logic          done_r;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; halt outranks everything while running.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nx_s = ST_RUN;
                else           state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.halt) state_nx_s = ST_DONE;
                else          state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (bus.start) state_nx_s = ST_RUN;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next PC / counter values for the current state and requests.
    always_comb begin
        prog_ctr_nx_s = prog_ctr_r;
        cycle_ct_nx_s = cycle_ct_r;
        jump_ct_nx_s  = jump_ct_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // A launch clears everything; otherwise values are frozen
                // (IDLE already holds the PC at 0 from reset or clear).
                if (bus.start) begin
                    prog_ctr_nx_s = {D{1'b0}};
                    cycle_ct_nx_s = {CW{1'b0}};
                    jump_ct_nx_s  = {CW{1'b0}};
                end else if (state_r == ST_IDLE) begin
                    prog_ctr_nx_s = {D{1'b0}};
                end else begin
                    prog_ctr_nx_s = prog_ctr_r;
                end
            end
            ST_RUN: begin
                // Every running cycle counts, including halt and stall cycles.
                cycle_ct_nx_s = sat_inc(cycle_ct_r);
                if (bus.halt || bus.stall) begin
                    // Halt parks on the halt instruction; a stalled jump is
                    // dropped and re-presented by the lookup later.
                    prog_ctr_nx_s = prog_ctr_r;
                end else if (bus.absj) begin
                    prog_ctr_nx_s = bus.target;
                    jump_ct_nx_s  = sat_inc(jump_ct_r);
                end else begin
                    prog_ctr_nx_s = prog_ctr_r + {{(D-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                prog_ctr_nx_s = {D{1'b0}};
            end
        endcase
    end

    // Output registers; status flags follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ctr_r <= {D{1'b0}};
            cycle_ct_r <= {CW{1'b0}};
            jump_ct_r  <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            prog_ctr_r <= prog_ctr_nx_s;
            cycle_ct_r <= cycle_ct_nx_s;
            jump_ct_r  <= jump_ct_nx_s;
            busy_r     <= (state_nx_s == ST_RUN);
            done_r     <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.prog_ctr = prog_ctr_r;
    assign bus.cycle_ct = cycle_ct_r;
    assign bus.jump_ct  = jump_ct_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule
